// File: rtl/idli_ex_serial_m.sv
// idli_ex_serial_m - slice-serial ALU/compare execute stage.
// Operands stream in SLICE_W bits per cycle, least significant slice first.
// Each RUN cycle produces one result slice combinationally. The carry and the
// zero accumulator are chained between slices. On the final slice the compare
// result is produced from {N,Z,C,V}.
// Optional feature: define IDLI_EX_FLAGS_OUT_EN to register {N,Z,C,V} into
// o_ex_flags on every final slice. Without it, o_ex_flags is tied to 0.
// Ports:
//   i_ex_gck, i_ex_rst_n        clock, async active-low reset
//   i_ex_op_vld / o_ex_op_acp   operation offer / accept handshake
//   i_ex_pred                   predicate (0 = discard offered op)
//   i_ex_alu_op, i_ex_rhs_inv, i_ex_cin, i_ex_cmp_op, i_ex_cmp_signed
//                               operation fields, latched on acceptance
//   i_ex_lhs, i_ex_rhs          operand slices
//   i_ex_stall, i_ex_flush      freeze / abort
//   o_ex_out, o_ex_out_vld      result slice (combinational)
//   o_ex_ctr                    slice index
//   o_ex_done, o_ex_cmp, o_ex_cmp_vld  final-slice strobe and compare result
//   o_ex_flags                  {N,Z,C,V} of the last completed operation
module idli_ex_serial_m #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SLICE_W = 4,
  localparam int unsigned NSLICE = DATA_W / SLICE_W,
  localparam int unsigned CTR_W  = $clog2(NSLICE)
) (
  input  logic               i_ex_gck,
  input  logic               i_ex_rst_n,
  input  logic               i_ex_op_vld,
  input  logic               i_ex_pred,
  input  logic [1:0]         i_ex_alu_op,
  input  logic               i_ex_rhs_inv,
  input  logic               i_ex_cin,
  input  logic [1:0]         i_ex_cmp_op,
  input  logic               i_ex_cmp_signed,
  output logic               o_ex_op_acp,
  input  logic [SLICE_W-1:0] i_ex_lhs,
  input  logic [SLICE_W-1:0] i_ex_rhs,
  input  logic               i_ex_stall,
  input  logic               i_ex_flush,
  output logic [SLICE_W-1:0] o_ex_out,
  output logic               o_ex_out_vld,
  output logic [CTR_W-1:0]   o_ex_ctr,
  output logic               o_ex_done,
  output logic               o_ex_cmp,
  output logic               o_ex_cmp_vld,
  output logic [3:0]         o_ex_flags
);

  localparam int unsigned SUM_W = SLICE_W + 1;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;

  localparam logic [1:0] CMP_EQ = 2'd0;
  localparam logic [1:0] CMP_NE = 2'd1;
  localparam logic [1:0] CMP_LT = 2'd2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic               carry_q, carry_d;
  logic               zacc_q, zacc_d;
  logic [1:0]         alu_op_q, alu_op_d;
  logic               rhs_inv_q, rhs_inv_d;
  logic               cin_q, cin_d;
  logic [1:0]         cmp_op_q, cmp_op_d;
  logic               cmp_signed_q, cmp_signed_d;

  logic [SLICE_W-1:0] rhs_eff;
  logic               cin_s;
  logic [SUM_W-1:0]   sum;
  logic [SLICE_W-1:0] res;
  logic               cout;
  logic               c_msb;
  logic               n_f, z_f, c_f, v_f;
  logic               cmp_raw;
  logic               last;
  logic               final_c;

  // Slice datapath: one SLICE_W-bit ALU step.
  always_comb begin
    rhs_eff = rhs_inv_q ? ~i_ex_rhs : i_ex_rhs;
    cin_s   = (ctr_q == '0) ? cin_q : carry_q;
    sum     = {1'b0, i_ex_lhs} + {1'b0, rhs_eff} + SUM_W'(cin_s);
    res     = sum[SLICE_W-1:0];
    cout    = 1'b0;
    c_msb   = 1'b0;
    case (alu_op_q)
      OP_ADD: begin
        cout  = sum[SLICE_W];
        // carry into the MSB recovered from the MSB sum bit
        c_msb = res[SLICE_W-1] ^ i_ex_lhs[SLICE_W-1] ^ rhs_eff[SLICE_W-1];
      end
      OP_AND:  res = i_ex_lhs & rhs_eff;
      OP_OR:   res = i_ex_lhs | rhs_eff;
      default: res = i_ex_lhs ^ rhs_eff;
    endcase
  end

  // Flags as seen on the current slice; meaningful on the final slice only.
  always_comb begin
    n_f = res[SLICE_W-1];
    z_f = zacc_q & (res == '0);
    c_f = cout;
    v_f = c_msb ^ cout;
    case (cmp_op_q)
      CMP_EQ:  cmp_raw = z_f;
      CMP_NE:  cmp_raw = ~z_f;
      CMP_LT:  cmp_raw = cmp_signed_q ? (n_f ^ v_f) : ~c_f;
      default: cmp_raw = cmp_signed_q ? ~(n_f ^ v_f) : c_f;
    endcase
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    carry_d      = carry_q;
    zacc_d       = zacc_q;
    alu_op_d     = alu_op_q;
    rhs_inv_d    = rhs_inv_q;
    cin_d        = cin_q;
    cmp_op_d     = cmp_op_q;
    cmp_signed_d = cmp_signed_q;

    last         = (ctr_q == CTR_W'(NSLICE - 1));
    final_c      = (state_q == RUN) && last && !i_ex_stall && !i_ex_flush;
    o_ex_op_acp  = (state_q == IDLE) || final_c;
    o_ex_out     = res;
    o_ex_out_vld = (state_q == RUN) && !i_ex_stall;
    o_ex_done    = final_c;
    o_ex_cmp_vld = final_c;
    o_ex_cmp     = final_c & cmp_raw;

    if (i_ex_flush) begin
      state_d = IDLE;
      ctr_d   = '0;
    end else if (state_q == RUN && !i_ex_stall) begin
      ctr_d   = ctr_q + CTR_W'(1);
      carry_d = cout;
      zacc_d  = z_f;
      if (last) begin
        state_d = IDLE;
      end
    end

    // Acceptance: latch fields; an unpredicated op is dropped in IDLE.
    if (!i_ex_flush && o_ex_op_acp && i_ex_op_vld) begin
      alu_op_d     = i_ex_alu_op;
      rhs_inv_d    = i_ex_rhs_inv;
      cin_d        = i_ex_cin;
      cmp_op_d     = i_ex_cmp_op;
      cmp_signed_d = i_ex_cmp_signed;
      zacc_d       = 1'b1;
      ctr_d        = '0;
      state_d      = i_ex_pred ? RUN : IDLE;
    end
  end

  // State and slice-chain registers.
  always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      state_q      <= IDLE;
      ctr_q        <= '0;
      carry_q      <= 1'b0;
      zacc_q       <= 1'b1;
      alu_op_q     <= 2'd0;
      rhs_inv_q    <= 1'b0;
      cin_q        <= 1'b0;
      cmp_op_q     <= 2'd0;
      cmp_signed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      carry_q      <= carry_d;
      zacc_q       <= zacc_d;
      alu_op_q     <= alu_op_d;
      rhs_inv_q    <= rhs_inv_d;
      cin_q        <= cin_d;
      cmp_op_q     <= cmp_op_d;
      cmp_signed_q <= cmp_signed_d;
    end
  end

  assign o_ex_ctr = ctr_q;

`ifdef IDLI_EX_FLAGS_OUT_EN
  logic [3:0] flags_q;

  // Flags of the last completed operation, held until the next final slice.
  always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      flags_q <= 4'b0;
    end else if (final_c) begin
      flags_q <= {n_f, z_f, c_f, v_f};
    end
  end

  assign o_ex_flags = flags_q;
`else
  assign o_ex_flags = 4'b0;
`endif

endmodule

// File: tb/tb_idli_ex_serial_m.sv
// Bench for idli_ex_serial_m: a 16/4 and a 32/8 instance run in lockstep
// (both have four slices). Expected results come from whole-word arithmetic.
module tb_idli_ex_serial_m;

  localparam int NS = 4;

  localparam logic [1:0] ADD = 2'd0, AND = 2'd1, OR = 2'd2, XOR = 2'd3;
  localparam logic [1:0] EQ = 2'd0, NE = 2'd1, LT = 2'd2, GE = 2'd3;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  aop;
    logic        inv;
    logic        ci;
    logic [1:0]  cop;
    logic        sgn;
    logic        pred;
  } op_t;

  typedef struct packed {
    logic [31:0] r;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n, op_vld, pred, rhs_inv, cin, cmp_signed, stall, flush;
  logic [1:0] alu_op, cmp_op;
  logic [3:0] lhs16, rhs16, out16, flags16;
  logic [7:0] lhs32, rhs32, out32;
  logic [3:0] flags32;
  logic [1:0] ctr16, ctr32;
  logic       acp16, ov16, done16, cmp16, cvld16;
  logic       acp32, ov32, done32, cmp32, cvld32;

  logic       chk_en, skip_ov, chained;
  logic       e_acp, e_ov, e_done, e_cvld, e_cmp16, e_cmp32;
  logic [1:0] e_ctr;
  logic [3:0] e_out16, e_fl16, e_fl32;
  logic [7:0] e_out32;

  int checks = 0;
  int errors = 0;

  idli_ex_serial_m #(.DATA_W(16), .SLICE_W(4)) u_dut16 (
    .i_ex_gck(clk), .i_ex_rst_n(rst_n), .i_ex_op_vld(op_vld), .i_ex_pred(pred),
    .i_ex_alu_op(alu_op), .i_ex_rhs_inv(rhs_inv), .i_ex_cin(cin),
    .i_ex_cmp_op(cmp_op), .i_ex_cmp_signed(cmp_signed), .o_ex_op_acp(acp16),
    .i_ex_lhs(lhs16), .i_ex_rhs(rhs16), .i_ex_stall(stall), .i_ex_flush(flush),
    .o_ex_out(out16), .o_ex_out_vld(ov16), .o_ex_ctr(ctr16), .o_ex_done(done16),
    .o_ex_cmp(cmp16), .o_ex_cmp_vld(cvld16), .o_ex_flags(flags16)
  );

  idli_ex_serial_m #(.DATA_W(32), .SLICE_W(8)) u_dut32 (
    .i_ex_gck(clk), .i_ex_rst_n(rst_n), .i_ex_op_vld(op_vld), .i_ex_pred(pred),
    .i_ex_alu_op(alu_op), .i_ex_rhs_inv(rhs_inv), .i_ex_cin(cin),
    .i_ex_cmp_op(cmp_op), .i_ex_cmp_signed(cmp_signed), .o_ex_op_acp(acp32),
    .i_ex_lhs(lhs32), .i_ex_rhs(rhs32), .i_ex_stall(stall), .i_ex_flush(flush),
    .o_ex_out(out32), .o_ex_out_vld(ov32), .o_ex_ctr(ctr32), .o_ex_done(done32),
    .o_ex_cmp(cmp32), .o_ex_cmp_vld(cvld32), .o_ex_flags(flags32)
  );

  always #5 clk = ~clk;

  // Whole-word result and flags of an operation at width w.
  function automatic res_t model(input op_t o, input int w);
    logic [63:0] mask, a, bb, full;
    res_t r;
    mask = (64'd1 << w) - 64'd1;
    a    = 64'(o.a) & mask;
    bb   = (o.inv ? ~64'(o.b) : 64'(o.b)) & mask;
    case (o.aop)
      ADD:     full = a + bb + 64'(o.ci);
      AND:     full = a & bb;
      OR:      full = a | bb;
      default: full = a ^ bb;
    endcase
    r.r = 32'(full & mask);
    r.c = full[w];
    r.n = full[w-1];
    r.z = ((full & mask) == 64'd0);
    r.v = (o.aop == ADD) && (a[w-1] == bb[w-1]) && (full[w-1] != a[w-1]);
    return r;
  endfunction

  function automatic logic cmpf(input res_t r, input logic [1:0] cop, input logic sgn);
    case (cop)
      EQ:      return r.z;
      NE:      return !r.z;
      LT:      return sgn ? (r.n != r.v) : !r.c;
      default: return sgn ? (r.n == r.v) : r.c;
    endcase
  endfunction

  function automatic logic [31:0] slc(input logic [31:0] v, input int k, input int s);
    return (v >> (k * s)) & ((32'd1 << s) - 32'd1);
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [1:0] aop,
                             input logic inv, input logic ci, input logic [1:0] cop,
                             input logic sgn, input logic pr);
    op_t o;
    o.a = a; o.b = b; o.aop = aop; o.inv = inv; o.ci = ci;
    o.cop = cop; o.sgn = sgn; o.pred = pr;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every mid-cycle, both instances against the expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("acp16", 32'(acp16), 32'(e_acp));
      chk("acp32", 32'(acp32), 32'(e_acp));
      chk("ctr16", 32'(ctr16), 32'(e_ctr));
      chk("ctr32", 32'(ctr32), 32'(e_ctr));
      chk("done16", 32'(done16), 32'(e_done));
      chk("done32", 32'(done32), 32'(e_done));
      chk("cvld16", 32'(cvld16), 32'(e_cvld));
      chk("cvld32", 32'(cvld32), 32'(e_cvld));
      chk("flags16", 32'(flags16), 32'(e_fl16));
      chk("flags32", 32'(flags32), 32'(e_fl32));
      if (!skip_ov) begin
        chk("ov16", 32'(ov16), 32'(e_ov));
        chk("ov32", 32'(ov32), 32'(e_ov));
        if (e_ov) begin
          chk("out16", 32'(out16), 32'(e_out16));
          chk("out32", 32'(out32), 32'(e_out32));
        end
      end
      if (e_cvld) begin
        chk("cmp16", 32'(cmp16), 32'(e_cmp16));
        chk("cmp32", 32'(cmp32), 32'(e_cmp32));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_acp = 1'b1; e_ctr = 2'd0; e_ov = 1'b0; e_done = 1'b0; e_cvld = 1'b0; skip_ov = 1'b0;
  endtask

  task automatic idle(input int n);
    op_vld = 1'b0; stall = 1'b0; flush = 1'b0;
    set_idle();
    repeat (n) step();
  endtask

  task automatic drive_fields(input op_t o);
    pred = o.pred; alu_op = o.aop; rhs_inv = o.inv; cin = o.ci;
    cmp_op = o.cop; cmp_signed = o.sgn;
  endtask

  // One operation: accept cycle (unless chained), then four slices with
  // optional stall, flush or reset injected at a chosen slice.
  task automatic run_op(input op_t o, input int stall_at, input int stall_len,
                        input int flush_at, input int rst_at,
                        input bit has_next, input op_t nxt);
    res_t r16, r32;
    r16 = model(o, 16);
    r32 = model(o, 32);
    if (!chained) begin
      drive_fields(o);
      op_vld = 1'b1;
      set_idle();
      step();
    end
    chained = 1'b0;
    op_vld  = 1'b0;
    drive_fields(op_t'(~o));
    if (!o.pred) return;
    for (int k = 0; k < NS; k++) begin
      lhs16 = 4'(slc(o.a, k, 4)); rhs16 = 4'(slc(o.b, k, 4));
      lhs32 = 8'(slc(o.a, k, 8)); rhs32 = 8'(slc(o.b, k, 8));
      e_ctr = 2'(k); e_acp = 1'b0; e_done = 1'b0; e_cvld = 1'b0; skip_ov = 1'b0;
      if (k == stall_at) begin
        stall = 1'b1; e_ov = 1'b0;
        repeat (stall_len) step();
        stall = 1'b0;
      end
      e_ov    = 1'b1;
      e_out16 = 4'(slc(r16.r, k, 4));
      e_out32 = 8'(slc(r32.r, k, 8));
      if (k == rst_at) begin
        rst_n = 1'b0;
        set_idle();
        e_fl16 = 4'd0; e_fl32 = 4'd0;
        step();
        rst_n = 1'b1;
        return;
      end
      if (k == flush_at) begin
        flush = 1'b1; skip_ov = 1'b1;
        step();
        flush = 1'b0; skip_ov = 1'b0;
        return;
      end
      if (k == NS - 1) begin
        e_acp = 1'b1; e_done = 1'b1; e_cvld = 1'b1;
        e_cmp16 = cmpf(r16, o.cop, o.sgn);
        e_cmp32 = cmpf(r32, o.cop, o.sgn);
        if (has_next) begin
          drive_fields(nxt);
          op_vld = 1'b1;
        end
      end
      step();
    end
    op_vld = 1'b0;
`ifdef IDLI_EX_FLAGS_OUT_EN
    e_fl16 = {r16.n, r16.z, r16.c, r16.v};
    e_fl32 = {r32.n, r32.z, r32.c, r32.v};
`endif
    chained = has_next && nxt.pred;
  endtask

  op_t  none, t_a, t_b, t_c;
  res_t pr;

  initial begin
    none = mk(32'h0, 32'h0, ADD, 1'b0, 1'b0, EQ, 1'b0, 1'b0);
    drive_fields(none);
    op_vld = 1'b0; stall = 1'b0; flush = 1'b0; rst_n = 1'b0; chained = 1'b0;
    lhs16 = 4'd0; rhs16 = 4'd0; lhs32 = 8'd0; rhs32 = 8'd0;
    e_out16 = 4'd0; e_out32 = 8'd0; e_cmp16 = 1'b0; e_cmp32 = 1'b0;
    e_fl16 = 4'd0; e_fl32 = 4'd0;
    set_idle();
    chk_en = 1'b1;

    // Hand-computed values pinning the model.
    pr = model(mk(32'h00FF, 32'h1, ADD, 1'b0, 1'b0, EQ, 1'b0, 1'b1), 16);
    chk("pin_add_r", pr.r, 32'h0100);
    chk("pin_add_c", 32'(pr.c), 32'd0);
    chk("pin_add_eq", 32'(cmpf(pr, EQ, 1'b0)), 32'd0);
    pr = model(mk(32'h5, 32'h5, ADD, 1'b1, 1'b1, EQ, 1'b0, 1'b1), 16);
    chk("pin_sub_r", pr.r, 32'h0);
    chk("pin_sub_z", 32'(pr.z), 32'd1);
    chk("pin_sub_c", 32'(pr.c), 32'd1);
    pr = model(mk(32'h8000, 32'h1, ADD, 1'b1, 1'b1, LT, 1'b1, 1'b1), 16);
    chk("pin_lt_r", pr.r, 32'h7FFF);
    chk("pin_lt_v", 32'(pr.v), 32'd1);
    chk("pin_lt_s", 32'(cmpf(pr, LT, 1'b1)), 32'd1);
    chk("pin_lt_u", 32'(cmpf(pr, LT, 1'b0)), 32'd0);
    pr = model(mk(32'hFFFFFFFF, 32'h1, ADD, 1'b0, 1'b0, EQ, 1'b0, 1'b1), 32);
    chk("pin_w32_r", pr.r, 32'h0);
    chk("pin_w32_c", 32'(pr.c), 32'd1);
    chk("pin_w32_z", 32'(pr.z), 32'd1);

    step(); step();
    rst_n = 1'b1;
    idle(2);

    run_op(mk(32'h000000FF, 32'h1, ADD, 1'b0, 1'b0, EQ, 1'b0, 1'b1), -1, 0, -1, -1, 1'b0, none);
    run_op(mk(32'h12340005, 32'h12340005, ADD, 1'b1, 1'b1, EQ, 1'b0, 1'b1), -1, 0, -1, -1, 1'b0, none);
    run_op(mk(32'h12340005, 32'h12340005, ADD, 1'b1, 1'b1, GE, 1'b0, 1'b1), -1, 0, -1, -1, 1'b0, none);
    idle(1);
    run_op(mk(32'h00008000, 32'h1, ADD, 1'b1, 1'b1, LT, 1'b1, 1'b1), -1, 0, -1, -1, 1'b0, none);
    run_op(mk(32'h80008000, 32'h1, ADD, 1'b1, 1'b1, LT, 1'b0, 1'b1), -1, 0, -1, -1, 1'b0, none);
    // stall held three cycles at slice 2 with a carry chain through it
    run_op(mk(32'h00FF0FFF, 32'h00010001, ADD, 1'b0, 1'b0, GE, 1'b0, 1'b1), 2, 3, -1, -1, 1'b0, none);
    // flush at slice 1, then acceptance must be offered again
    run_op(mk(32'h1111, 32'h2222, ADD, 1'b0, 1'b0, EQ, 1'b0, 1'b1), -1, 0, 1, -1, 1'b0, none);
    idle(1);
    // unpredicated op is dropped
    run_op(mk(32'h1, 32'h1, ADD, 1'b0, 1'b0, EQ, 1'b0, 1'b0), -1, 0, -1, -1, 1'b0, none);
    idle(1);
    // back-to-back chain, the third op being unpredicated
    t_a = mk(32'hF0F0F0F0, 32'hFF00FF00, AND, 1'b0, 1'b0, LT, 1'b0, 1'b1);
    t_b = mk(32'hAAAA5555, 32'h5555AAAA, XOR, 1'b0, 1'b1, NE, 1'b0, 1'b1);
    t_c = mk(32'h0, 32'h0, OR, 1'b0, 1'b0, EQ, 1'b0, 1'b0);
    run_op(t_a, -1, 0, -1, -1, 1'b1, t_b);
    run_op(t_b, -1, 0, -1, -1, 1'b1, t_c);
    idle(2);
    run_op(mk(32'h00001234, 32'h0000FFFF, OR, 1'b1, 1'b0, GE, 1'b1, 1'b1), -1, 0, -1, -1, 1'b0, none);
    run_op(mk(32'hFFFFFFFF, 32'h1, ADD, 1'b0, 1'b0, EQ, 1'b0, 1'b1), -1, 0, -1, -1, 1'b0, none);
    run_op(mk(32'hFFFFFFFF, 32'h1, ADD, 1'b0, 1'b0, GE, 1'b0, 1'b1), -1, 0, -1, -1, 1'b0, none);
    run_op(mk(32'h7FFF7FFF, 32'h1, ADD, 1'b0, 1'b0, LT, 1'b1, 1'b1), -1, 0, -1, -1, 1'b0, none);
    // reset mid-operation at slice 2
    run_op(mk(32'h00FF, 32'h1, ADD, 1'b0, 1'b0, EQ, 1'b0, 1'b1), -1, 0, -1, 2, 1'b0, none);
    idle(2);
    run_op(mk(32'h000000FF, 32'h1, ADD, 1'b0, 1'b0, EQ, 1'b0, 1'b1), -1, 0, -1, -1, 1'b0, none);
    idle(1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
